// File: rtl/lenet_feeder_pkg.sv
// Shared types and helpers for the LeNet input-buffer feeder.
package lenet_feeder_pkg;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_STREAM = 2'd2,
      S_RESULT = 2'd3
   } feeder_state_t;

   localparam int unsigned IMG_DEF = 32;
   localparam int unsigned PAD_DEF = 2;

   // True for pixels in the zero border that the capture core never writes.
   function automatic logic is_border(input int unsigned idx,
                                      input int unsigned img,
                                      input int unsigned pad);
      int unsigned row;
      int unsigned col;
      row = idx / img;
      col = idx % img;
      return (row < pad) || (col < pad) || (row >= img - pad) || (col >= img - pad);
   endfunction

endpackage

// File: rtl/lenet_skid_fifo.sv
// Two-entry output FIFO; entry 0 is always the head, so the head is a plain register.
module lenet_skid_fifo #(
   parameter int unsigned W = 11
) (
   input  logic         clk25,
   input  logic         rst_n,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] din_i,
   output logic [W-1:0] head_o,
   output logic [1:0]   count_o
);

   logic [W-1:0] e0_q, e0_d;
   logic [W-1:0] e1_q, e1_d;
   logic [1:0]   cnt_q, cnt_d;

   always_comb begin
      e0_d  = e0_q;
      e1_d  = e1_q;
      cnt_d = cnt_q;
      case ({push_i, pop_i})
         2'b10: begin
            if (cnt_q == 2'd0) e0_d = din_i;
            else               e1_d = din_i;
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            e0_d  = e1_q;
            cnt_d = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               e0_d = din_i;
            end else begin
               e0_d = e1_q;
               e1_d = din_i;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o  = e0_q;
   assign count_o = cnt_q;

endmodule

// File: rtl/lenet_feeder.sv
// Reads the padded LeNet image from buffer port B and streams it to the CNN,
// then holds the returned classification for the display overlay.
module lenet_feeder
   import lenet_feeder_pkg::*;
#(
   parameter int unsigned IMG = IMG_DEF,
   parameter int unsigned PAD = PAD_DEF,
   parameter int unsigned DW  = 8,
   parameter int unsigned AW  = 10
) (
   input  logic          clk25,
   input  logic          rst_n,
   input  logic          data_ready,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          m_valid,
   input  logic          m_ready,
   output logic [DW-1:0] m_data,
   output logic          m_first,
   output logic          m_last,
   output logic          busy,
   input  logic          res_valid,
   input  logic [3:0]    res_digit,
   output logic [3:0]    digit,
   output logic          digit_valid,
   output logic [7:0]    drop_cnt
);

   localparam int unsigned    NPIX      = IMG * IMG;
   localparam int unsigned    FW        = DW + 3;
   localparam logic [AW-1:0]  LAST_IDX  = AW'(NPIX - 1);
   localparam logic [AW-1:0]  FIRST_INT = AW'(PAD * IMG + PAD);

   feeder_state_t state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          issue_done_q, issue_done_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic          infl_q, infl_d;
   logic          infl_border_q, infl_border_d;
   logic          infl_first_q, infl_first_d;
   logic          infl_last_q, infl_last_d;
   logic [7:0]    drop_q, drop_d;
   logic [3:0]    digit_q, digit_d;
   logic          dv_q, dv_d;

   logic [1:0]    fifo_count;
   logic [FW-1:0] fifo_head;
   logic [FW-1:0] fifo_din;
   logic          pop;
   logic          issue;
   logic          cur_border;
   logic          head_border;
   logic [DW-1:0] head_data;
   logic [2:0]    occ;

   lenet_skid_fifo #(.W(FW)) u_fifo (
      .clk25   (clk25),
      .rst_n   (rst_n),
      .push_i  (infl_q),
      .pop_i   (pop),
      .din_i   (fifo_din),
      .head_o  (fifo_head),
      .count_o (fifo_count)
   );

   assign fifo_din = {infl_border_q, infl_first_q, infl_last_q, rd_data};
   assign {head_border, m_first, m_last, head_data} = fifo_head;
   // Border slots carry whatever port B returned; the flag zeroes them here.
   assign m_data   = head_border ? '0 : head_data;
   assign m_valid  = fifo_count != 2'd0;
   assign pop      = m_valid && m_ready;

   assign cur_border = is_border(32'(idx_q), IMG, PAD);
   assign occ        = 3'(fifo_count) + 3'(infl_q) - 3'(pop);
   assign issue      = (state_q == S_STREAM) && !issue_done_q && (occ < 3'd2);

   // Address follows idx regardless of issue so m_ready never reaches rd_addr;
   // a stalled read is simply repeated. Border indices keep the last real address.
   assign rd_addr = ((state_q == S_STREAM) && !issue_done_q && !cur_border) ? idx_q : rd_addr_q;

   always_comb begin
      state_d       = state_q;
      idx_d         = idx_q;
      issue_done_d  = issue_done_q;
      rd_addr_d     = rd_addr;
      infl_d        = issue;
      infl_border_d = cur_border;
      infl_first_d  = idx_q == '0;
      infl_last_d   = idx_q == LAST_IDX;
      drop_d        = drop_q;
      digit_d       = digit_q;
      dv_d          = dv_q;

      if (data_ready && (state_q != S_IDLE) && (drop_q != '1)) drop_d = drop_q + 8'd1;

      case (state_q)
         S_IDLE: begin
            if (data_ready) begin
               state_d      = S_ARM;
               idx_d        = '0;
               issue_done_d = 1'b0;
               rd_addr_d    = FIRST_INT;
            end
         end
         S_ARM: state_d = S_STREAM;
         S_STREAM: begin
            if (issue) begin
               if (idx_q == LAST_IDX) issue_done_d = 1'b1;
               else                   idx_d = idx_q + AW'(1);
            end
            if (pop && m_last) state_d = S_RESULT;
         end
         S_RESULT: begin
            if (res_valid) begin
               state_d = S_IDLE;
               idx_d   = '0;
               digit_d = res_digit;
               dv_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk25 or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         issue_done_q  <= 1'b0;
         rd_addr_q     <= '0;
         infl_q        <= 1'b0;
         infl_border_q <= 1'b0;
         infl_first_q  <= 1'b0;
         infl_last_q   <= 1'b0;
         drop_q        <= '0;
         digit_q       <= '0;
         dv_q          <= 1'b0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         issue_done_q  <= issue_done_d;
         rd_addr_q     <= rd_addr_d;
         infl_q        <= infl_d;
         infl_border_q <= infl_border_d;
         infl_first_q  <= infl_first_d;
         infl_last_q   <= infl_last_d;
         drop_q        <= drop_d;
         digit_q       <= digit_d;
         dv_q          <= dv_d;
      end
   end

   assign busy        = state_q != S_IDLE;
   assign digit       = digit_q;
   assign digit_valid = dv_q;
   assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_lenet_feeder.sv
// Directed bench for lenet_feeder with a 1-cycle-latency buffer model.
module tb_lenet_feeder;

   logic       clk25 = 1'b0;
   logic       rst_n;
   logic       data_ready;
   logic [9:0] rd_addr;
   logic [7:0] rd_data;
   logic       m_valid;
   logic       m_ready;
   logic [7:0] m_data;
   logic       m_first;
   logic       m_last;
   logic       busy;
   logic       res_valid;
   logic [3:0] res_digit;
   logic [3:0] digit;
   logic       digit_valid;
   logic [7:0] drop_cnt;

   logic [7:0] mem [1024];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   int   beat_idx, bad_beats, first_valid_cyc, last_cyc, rd_bad, stall_bad;
   bit   rnd_mode;
   logic prev_stall;
   logic [7:0] prev_data, data66, last_data;
   logic prev_first, prev_lastf;
   int   start;

   always #5 clk25 = ~clk25;

   lenet_feeder #(.IMG(32), .PAD(2), .DW(8), .AW(10)) dut (
      .clk25       (clk25),
      .rst_n       (rst_n),
      .data_ready  (data_ready),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_first     (m_first),
      .m_last      (m_last),
      .busy        (busy),
      .res_valid   (res_valid),
      .res_digit   (res_digit),
      .digit       (digit),
      .digit_valid (digit_valid),
      .drop_cnt    (drop_cnt)
   );

   always @(posedge clk25) rd_data <= mem[rd_addr];

   function automatic bit tb_border(input int i);
      return (i / 32 < 2) || (i % 32 < 2) || (i / 32 >= 30) || (i % 32 >= 30);
   endfunction

   function automatic logic [7:0] exp_pix(input int i);
      return tb_border(i) ? 8'h00 : 8'(i);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk25);
      cyc++;
      if (rnd_mode) m_ready = 1'($urandom_range(0, 1));
      if (busy && tb_border(int'(rd_addr))) rd_bad++;
      if (prev_stall && !(m_valid === 1'b1 && m_data === prev_data &&
                          m_first === prev_first && m_last === prev_lastf)) stall_bad++;
      if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
         if (beat_idx >= 1024 || m_data !== exp_pix(beat_idx) ||
             m_first !== (beat_idx == 0) || m_last !== (beat_idx == 1023)) bad_beats++;
         if (beat_idx == 66) data66 = m_data;
         if (m_last) begin
            last_cyc  = cyc;
            last_data = m_data;
         end
         beat_idx++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_first = m_first;
      prev_lastf = m_last;
   endtask

   // mode 0: plain frame; 1: 3 drops + stray result in STREAM; 2: 300 drop pulses
   task automatic run_frame(input bit rnd, input int mode, input int stop_beat);
      beat_idx = 0; bad_beats = 0; first_valid_cyc = -1; last_cyc = -1;
      rd_bad = 0; stall_bad = 0; prev_stall = 1'b0; rnd_mode = rnd;
      data_ready = 1'b1;
      start = cyc;
      tick();
      for (int k = 1; k < 6000 && beat_idx < stop_beat; k++) begin
         data_ready = (mode == 1 && (k == 10 || k == 50 || k == 200)) ||
                      (mode == 2 && k >= 5 && k < 305);
         res_valid  = (mode == 1 && k == 30);
         res_digit  = 4'd5;
         tick();
      end
      data_ready = 1'b0;
      res_valid  = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      rst_n = 1'b0; data_ready = 1'b0; m_ready = 1'b0;
      res_valid = 1'b0; res_digit = 4'd0; rnd_mode = 1'b0; prev_stall = 1'b0;
      beat_idx = 0; bad_beats = 0; first_valid_cyc = -1; last_cyc = -1; rd_bad = 0; stall_bad = 0;
      tick(); tick();
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_first", m_first, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_digit", digit, 0);
      chk("rst_digit_valid", digit_valid, 0);
      chk("rst_drop_cnt", drop_cnt, 0);
      rst_n = 1'b1;
      tick();

      // Frame 1: m_ready held high
      m_ready = 1'b1;
      run_frame(1'b0, 0, 1024);
      chk("f1_beats", beat_idx, 1024);
      chk("f1_bad_beats", bad_beats, 0);
      chk("f1_first_valid_lat", first_valid_cyc - start, 4);
      chk("f1_last_lat", last_cyc - start, 1027);
      chk("f1_beat66", data66, 8'h42);
      chk("f1_last_data", last_data, 8'h00);
      chk("f1_border_reads", rd_bad, 0);
      tick();
      chk("f1_busy_result", busy, 1);
      chk("f1_m_valid_result", m_valid, 0);
      chk("f1_dv_before_result", digit_valid, 0);
      res_valid = 1'b1; res_digit = 4'd7;
      tick();
      res_valid = 1'b0;
      chk("f1_digit", digit, 7);
      chk("f1_digit_valid", digit_valid, 1);
      chk("f1_busy_idle", busy, 0);
      res_valid = 1'b1; res_digit = 4'd3;
      tick();
      res_valid = 1'b0;
      chk("idle_res_ignored", digit, 7);

      // Frame 2: random back-pressure, drops and a stray result strobe
      run_frame(1'b1, 1, 1024);
      chk("f2_beats", beat_idx, 1024);
      chk("f2_bad_beats", bad_beats, 0);
      chk("f2_stall_unstable", stall_bad, 0);
      chk("f2_border_reads", rd_bad, 0);
      chk("f2_first_valid_lat", first_valid_cyc - start, 4);
      tick();
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      chk("f2_drop_cnt", drop_cnt, 4);
      chk("f2_stream_res_ignored", digit, 7);
      res_valid = 1'b1; res_digit = 4'd2;
      tick();
      res_valid = 1'b0;
      chk("f2_digit", digit, 2);
      chk("f2_busy_idle", busy, 0);

      // Frame 3: reset at beat 500, then full restart
      rnd_mode = 1'b0; m_ready = 1'b1;
      run_frame(1'b0, 0, 500);
      chk("f3_reached_500", beat_idx, 500);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_m_valid", m_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_m_data", m_data, 0);
      chk("mid_rst_m_first", m_first, 0);
      chk("mid_rst_m_last", m_last, 0);
      chk("mid_rst_rd_addr", rd_addr, 0);
      chk("mid_rst_digit", digit, 0);
      chk("mid_rst_digit_valid", digit_valid, 0);
      chk("mid_rst_drop_cnt", drop_cnt, 0);
      tick();
      rst_n = 1'b1;
      run_frame(1'b0, 0, 1024);
      chk("f3_beats", beat_idx, 1024);
      chk("f3_bad_beats", bad_beats, 0);
      chk("f3_first_valid_lat", first_valid_cyc - start, 4);
      chk("f3_last_lat", last_cyc - start, 1027);
      tick();
      res_valid = 1'b1; res_digit = 4'd9;
      tick();
      res_valid = 1'b0;
      chk("f3_digit", digit, 9);

      // Frame 4: drop counter saturation
      run_frame(1'b0, 2, 1024);
      chk("f4_beats", beat_idx, 1024);
      chk("f4_bad_beats", bad_beats, 0);
      chk("f4_drop_sat", drop_cnt, 255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
